// File: rtl/apb_pkg.sv
// apb_pkg: FSM encoding and width helpers shared by the APB
// master and its completer decoder.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A single completer still needs one select bit
  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/apb_slv_decode.sv
// apb_slv_decode: maps the top address bits to a completer and
// muxes that completer's response lines.
module apb_slv_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
) (
  input  logic [ADDR_W-1:0]         addr,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic [sel_w(NUM_SLV)-1:0] index,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      dec_err,
  output logic [DATA_W-1:0]         sel_prdata,
  output logic                      sel_pready,
  output logic                      sel_pslverr
);

  localparam int SEL_W = sel_w(NUM_SLV);

  logic unused_addr;

  assign unused_addr = ^addr;
  assign index       = addr[ADDR_W-1 -: SEL_W];
  assign dec_err     = 32'(index) >= NUM_SLV;

  always_comb begin
    psel        = '0;
    sel_prdata  = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (index == SEL_W'(i)) begin
        psel[i]     = 1'b1;
        sel_prdata  = prdata[i*DATA_W +: DATA_W];
        sel_pready  = pready[i];
        sel_pslverr = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/apb_master_multi.sv
// apb_master_multi: single-outstanding APB requester fanning out
// to NUM_SLV completers, with decode-error and timeout aborts.
module apb_master_multi
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int CNT_W = clog2(TIMEOUT + 1);

  apb_state_t state;
  logic [CNT_W-1:0] cnt;

  logic [ADDR_W-1:0]         dec_addr;
  logic [sel_w(NUM_SLV)-1:0] unused_idx;
  logic [NUM_SLV-1:0]        dec_psel;
  logic                      dec_err;
  logic [DATA_W-1:0]         sel_prdata;
  logic                      sel_pready;
  logic                      sel_pslverr;

  assign req_ready = (state == IDLE);

  // Decode the incoming request while idle so PSEL is registered
  // in time for SETUP; afterwards decode the held PADDR.
  assign dec_addr = (state == IDLE) ? req_addr : PADDR;

  apb_slv_decode #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_SLV(NUM_SLV)
  ) u_dec (
    .addr       (dec_addr),
    .prdata     (PRDATA),
    .pready     (PREADY),
    .pslverr    (PSLVERR),
    .index      (unused_idx),
    .psel       (dec_psel),
    .dec_err    (dec_err),
    .sel_prdata (sel_prdata),
    .sel_pready (sel_pready),
    .sel_pslverr(sel_pslverr)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            PWRITE <= req_write;
            PADDR  <= req_addr;
            PWDATA <= req_wdata;
            PSEL   <= dec_psel;
            cnt    <= '0;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (dec_err) begin
            PSEL      <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= IDLE;
          end else begin
            PENABLE <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (sel_pready) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= sel_pslverr;
            rsp_rdata <= (!PWRITE && !sel_pslverr) ? sel_prdata : '0;
            state     <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_multi.sv
// tb_apb_master_multi: directed transfers against two master
// configurations with a queued scoreboard and bus monitors.
module tb_apb_master_multi;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int N2 = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [3:0]  psel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  logic           req_valid, req_ready, req_write;
  logic [AW-1:0]  req_addr;
  logic [DW-1:0]  req_wdata;
  logic           rsp_valid, rsp_err;
  logic [DW-1:0]  rsp_rdata;
  logic [NS-1:0]  PSEL, PREADY, PSLVERR;
  logic           PENABLE, PWRITE;
  logic [AW-1:0]  PADDR;
  logic [DW-1:0]  PWDATA;
  logic [NS*DW-1:0] PRDATA;

  logic           b_req_valid, b_req_ready, b_req_write;
  logic [AW-1:0]  b_req_addr;
  logic [DW-1:0]  b_req_wdata;
  logic           b_rsp_valid, b_rsp_err;
  logic [DW-1:0]  b_rsp_rdata;
  logic [N2-1:0]  b_psel, b_pready, b_pslverr;
  logic           b_penable, b_pwrite;
  logic [AW-1:0]  b_paddr;
  logic [DW-1:0]  b_pwdata;
  logic [N2*DW-1:0] b_prdata;

  apb_master_multi #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master_multi #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(N2), .TIMEOUT(16)
  ) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite),
    .PADDR(b_paddr), .PWDATA(b_pwdata), .PRDATA(b_prdata),
    .PREADY(b_pready), .PSLVERR(b_pslverr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q[$];
  exp_t bq[$];
  int   aq[$];
  int   baq[$];

  // Completer model for the 4-slave master; unselected slaves
  // present ready/error/junk data that must be ignored.
  int          ws[NS];
  logic [31:0] rd[NS];
  logic        err_w[NS];
  logic        err_r[NS];
  int          acc_n = 0;

  always @(negedge PCLK) acc_n = PENABLE ? acc_n + 1 : 0;

  always @* begin
    PRDATA  = '0;
    PREADY  = '0;
    PSLVERR = '0;
    for (int i = 0; i < NS; i++) begin
      if (PSEL[i]) begin
        PREADY[i]  = PENABLE && (acc_n > ws[i]);
        PSLVERR[i] = PWRITE ? err_w[i] : err_r[i];
        PRDATA[i*DW +: DW] = rd[i];
      end else begin
        PREADY[i]  = 1'b1;
        PSLVERR[i] = 1'b1;
        PRDATA[i*DW +: DW] = 32'hBAD0_0000 | 32'(i);
      end
    end
  end

  assign b_pready  = '1;
  assign b_pslverr = '0;
  assign b_prdata  = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge PCLK) begin
    if (PRESETn && req_valid && req_ready) aq.push_back(cyc);
    if (PRESETn && b_req_valid && b_req_ready) baq.push_back(cyc);
    cyc++;
  end

  exp_t       m_e;
  int         m_a;
  logic [3:0] prev_psel = '0;

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      prev_psel = '0;
    end else begin
      if (PSEL != '0 || PENABLE) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL apb_idle: PSEL=%b with no transfer", PSEL);
        end else begin
          chk("apb_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
              {q[0].psel, prev_psel != '0, q[0].wr, q[0].addr,
               q[0].wdata});
        end
      end
      if (rsp_valid) begin
        if (q.size() == 0 || aq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_spurious: rsp_valid with nothing due");
        end else begin
          m_e = q.pop_front();
          m_a = aq.pop_front();
          chk("rsp_data", {rsp_err, rsp_rdata}, {m_e.err, m_e.rdata});
          chk("rsp_latency", 128'(cyc - m_a), 128'(m_e.lat));
          chk("rsp_idle", {req_ready, PSEL, PENABLE},
              {1'b1, 4'b0000, 1'b0});
        end
      end
      prev_psel = PSEL;
    end
  end

  exp_t b_e;
  int   b_a;

  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (b_psel != '0) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_apb_idle: PSEL=%b with no transfer", b_psel);
        end else begin
          chk("b_apb_psel", {1'b0, b_psel}, bq[0].psel);
        end
      end
      if (b_rsp_valid) begin
        if (bq.size() == 0 || baq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_rsp_spurious: rsp_valid with nothing due");
        end else begin
          b_e = bq.pop_front();
          b_a = baq.pop_front();
          chk("b_rsp_data", {b_rsp_err, b_rsp_rdata},
              {b_e.err, b_e.rdata});
          chk("b_rsp_latency", 128'(cyc - b_a), 128'(b_e.lat));
          chk("b_rsp_psel", {1'b0, b_psel}, 4'b0000);
        end
      end
    end
  end

  task automatic issue(input bit sel, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input exp_t e, output int acc);
    int n;
    n = 0;
    @(negedge PCLK);
    if (sel) begin
      bq.push_back(e);
      b_req_valid = 1'b1;
      b_req_write = w;
      b_req_addr  = a;
      b_req_wdata = d;
    end else begin
      q.push_back(e);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
    end
    while (!(sel ? b_req_ready : req_ready) && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    if (!(sel ? b_req_ready : req_ready)) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready stuck low");
    end
    acc = cyc;
    @(posedge PCLK);
    #1;
    req_valid   = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bq.size() != 0) && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (q.size() != 0 || bq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d/%0d responses never came",
               q.size(), bq.size());
      q.delete();
      bq.delete();
    end
    @(negedge PCLK);
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, {req_ready, rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE,
             PWRITE, PADDR, PWDATA},
        {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int a1, a2;

  initial begin
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = '0; b_req_wdata = '0;
    for (int i = 0; i < NS; i++) begin
      ws[i] = 0;
      rd[i] = 32'h1111_1111 * (i + 1);
      err_w[i] = 1'b0;
      err_r[i] = 1'b0;
    end
    repeat (3) @(negedge PCLK);
    chk_reset("reset_state");
    chk("b_reset_state",
        {b_req_ready, b_rsp_valid, b_rsp_err, b_rsp_rdata, b_psel,
         b_penable, b_pwrite, b_paddr, b_pwdata},
        {1'b1, 1'b0, 1'b0, 32'h0, 3'h0, 1'b0, 1'b0, 32'h0, 32'h0});
    PRESETn = 1'b1;

    // Zero-wait write to slave 1
    issue(0, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF,
          '{32'h0, 1'b0, 3, 4'b0010, 1'b1, 32'h4000_0010,
            32'hDEAD_BEEF}, a1);
    drain();

    // Read slave 3 with three wait states
    ws[3] = 3;
    rd[3] = 32'h1234_5678;
    issue(0, 1'b0, 32'hC000_0004, 32'h0,
          '{32'h1234_5678, 1'b0, 6, 4'b1000, 1'b0, 32'hC000_0004,
            32'h0}, a1);
    drain();

    // Slave 0 never ready: timeout after 16 ACCESS cycles
    ws[0] = 1000;
    rd[0] = 32'h0BAD_0BAD;
    issue(0, 1'b0, 32'h0000_0008, 32'h77,
          '{32'h0, 1'b1, 18, 4'b0001, 1'b0, 32'h0000_0008,
            32'h77}, a1);
    drain();

    // Erroring write then back-to-back clean read on slave 2
    ws[0] = 0;
    err_w[2] = 1'b1;
    rd[2] = 32'hA5A5_0002;
    issue(0, 1'b1, 32'h8000_0020, 32'h55AA_55AA,
          '{32'h0, 1'b1, 3, 4'b0100, 1'b1, 32'h8000_0020,
            32'h55AA_55AA}, a1);
    issue(0, 1'b0, 32'h8000_0024, 32'h0,
          '{32'hA5A5_0002, 1'b0, 3, 4'b0100, 1'b0, 32'h8000_0024,
            32'h0}, a2);
    chk("b2b_accept", 128'(a2 - a1), 128'(3));
    drain();

    // Read error must zero the returned data
    err_r[1] = 1'b1;
    rd[1] = 32'hFEED_F00D;
    issue(0, 1'b0, 32'h4000_0000, 32'h0,
          '{32'h0, 1'b1, 3, 4'b0001 << 1, 1'b0, 32'h4000_0000,
            32'h0}, a1);
    drain();

    // Reset in the middle of ACCESS drops the transfer
    ws[0] = 1000;
    issue(0, 1'b0, 32'h0000_0040, 32'h0,
          '{32'h0, 1'b1, 18, 4'b0001, 1'b0, 32'h0000_0040,
            32'h0}, a1);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b0;
    @(negedge PCLK);
    q.delete();
    aq.delete();
    chk_reset("reset_mid_access");
    PRESETn = 1'b1;
    ws[0] = 0;
    issue(0, 1'b1, 32'h0000_0100, 32'h0000_0001,
          '{32'h0, 1'b0, 3, 4'b0001, 1'b1, 32'h0000_0100,
            32'h0000_0001}, a1);
    drain();

    // Three-slave master: index 3 is a decode error
    issue(1, 1'b0, 32'hC000_0000, 32'h0,
          '{32'h0, 1'b1, 2, 4'b0000, 1'b0, 32'hC000_0000,
            32'h0}, a1);
    drain();
    issue(1, 1'b0, 32'h8000_0000, 32'h0,
          '{32'h3333_0002, 1'b0, 3, 4'b0100, 1'b0, 32'h8000_0000,
            32'h0}, a1);
    drain();

    repeat (3) @(negedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
